// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and counter sizing.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  // Bits needed for a counter that runs 0..lim-1 (never narrower than 1).
  function automatic int cnt_w(input int lim);
    return (lim <= 2) ? 1 : $clog2(lim);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, synchronously cleared.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d, sync_q;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies a synchronised lock, then
// releases downstream resets in staggered order; retries on timeout, faults when exhausted.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_RESETS          = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic [NUM_RESETS-1:0]              rst_out,
  output logic                               ready,
  output logic                               lock_lost,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int PRW = cnt_w(PLL_RST_CYCLES);
  localparam int TOW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int STW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int RLW = cnt_w(STAGGER_CYCLES*NUM_RESETS + 1);
  localparam int RCW = $clog2(MAX_RETRIES+1);

  localparam logic [PRW-1:0] PR_LAST = PRW'(PLL_RST_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STW-1:0] ST_LAST = STW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RLW-1:0] RL_MAX  = RLW'(STAGGER_CYCLES*NUM_RESETS);
  localparam logic [RCW-1:0] RC_LAST = RCW'(MAX_RETRIES - 1);
  localparam logic [RCW-1:0] RC_MAX  = RCW'(MAX_RETRIES);

  logic locked_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  state_e                state_d, state_q;
  logic                  pll_rst_d, pll_rst_q;
  logic [NUM_RESETS-1:0] rst_out_d, rst_out_q;
  logic                  ready_d, ready_q;
  logic                  lock_lost_d, lock_lost_q;
  logic                  fault_d, fault_q;
  logic [RCW-1:0]        retry_d, retry_q;
  logic [PRW-1:0]        pr_cnt_d, pr_cnt_q;
  logic [TOW-1:0]        to_cnt_d, to_cnt_q;
  logic [STW-1:0]        st_cnt_d, st_cnt_q;
  logic [RLW-1:0]        rel_cnt_d, rel_cnt_q;

  always_comb begin
    state_d     = state_q;
    pll_rst_d   = pll_rst_q;
    rst_out_d   = rst_out_q;
    ready_d     = 1'b0;
    lock_lost_d = 1'b0;
    fault_d     = fault_q;
    retry_d     = retry_q;
    pr_cnt_d    = pr_cnt_q;
    to_cnt_d    = to_cnt_q;
    st_cnt_d    = st_cnt_q;
    rel_cnt_d   = rel_cnt_q;

    case (state_q)
      PLL_RESET: begin
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        if (pr_cnt_q == PR_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          to_cnt_d  = '0;
        end else begin
          pr_cnt_d = pr_cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (locked_s) begin
          state_d  = QUALIFY;
          st_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          pll_rst_d = 1'b1;
          if (retry_q == RC_LAST) begin
            state_d = FAULT;
            retry_d = RC_MAX;
            fault_d = 1'b1;
          end else begin
            state_d  = PLL_RESET;
            retry_d  = retry_q + 1'b1;
            pr_cnt_d = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      QUALIFY: begin
        // Timeout counter is frozen here so a flicker resumes the same budget.
        if (!locked_s) begin
          state_d     = WAIT_LOCK;
          lock_lost_d = 1'b1;
          st_cnt_d    = '0;
        end else if (st_cnt_q == ST_LAST) begin
          state_d   = RELEASE;
          rel_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end

      RELEASE, RUN: begin
        if (!locked_s) begin
          state_d     = PLL_RESET;
          pll_rst_d   = 1'b1;
          rst_out_d   = '1;
          lock_lost_d = 1'b1;
          pr_cnt_d    = '0;
        end else if (state_q == RUN) begin
          ready_d = 1'b1;
        end else if (!rst_out_q[NUM_RESETS-1]) begin
          state_d = RUN;
          ready_d = 1'b1;
          retry_d = '0;
        end else begin
          rel_cnt_d = (rel_cnt_q == RL_MAX) ? rel_cnt_q : rel_cnt_q + 1'b1;
          // Bits only ever clear here; reassertion is all-at-once on lock loss.
          for (int i = 0; i < NUM_RESETS; i++) begin
            if (rel_cnt_d >= RLW'(STAGGER_CYCLES*(i+1))) rst_out_d[i] = 1'b0;
          end
        end
      end

      FAULT: begin
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        fault_d   = 1'b1;
      end

      default: begin
        state_d   = PLL_RESET;
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        pr_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      pll_rst_q   <= 1'b1;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
      pr_cnt_q    <= '0;
      to_cnt_q    <= '0;
      st_cnt_q    <= '0;
      rel_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      fault_q     <= fault_d;
      retry_q     <= retry_d;
      pr_cnt_q    <= pr_cnt_d;
      to_cnt_q    <= to_cnt_d;
      st_cnt_q    <= st_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_out     = rst_out_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule
